// File: rtl/shift_deser.sv
// Serial-to-parallel deserializer: sof-framed bits assemble into a WIDTH-bit word, presented the cycle after the last bit.
// Output is a one-deep valid/ready register; a word completing while that register is held is dropped and flags overrun.
module shift_deser #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sof,
  input  logic             clr_err,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun,
  output logic             sync_err
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    idx;
  logic [CW-1:0]    pos;
  logic             restart;
  logic             take;
  logic             complete;

  // word is the shift register with the current bit merged in; a sof bit starts from an empty word
  always_comb begin
    restart  = sin_valid && sof;
    take     = sin_valid && (sof || (state == SHIFT));
    idx      = restart ? '0 : cnt;
    pos      = MSB_FIRST ? (CW'(WIDTH - 1) - idx) : idx;
    word     = restart ? '0 : sr;
    word[pos] = sin;
    complete = take && (idx == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      sync_err <= restart && (state == SHIFT);

      if (take) begin
        if (complete) begin
          state <= IDLE;
          cnt   <= '0;
          sr    <= '0;
        end else begin
          state <= SHIFT;
          cnt   <= idx + CW'(1);
          sr    <= word;
        end
      end

      // a word completing on the same edge the consumer drains the old one replaces it directly
      if (complete && (!out_valid || out_ready)) begin
        out       <= word;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (complete && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_shift_deser.sv
// Randomized and directed bench for shift_deser with a queue-based reference model and a decoupled output monitor.
module tb_shift_deser;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic         sof = 1'b0;
  logic         clr_err = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] out, out0;
  logic         out_valid, busy, overrun, sync_err;
  logic         out_valid0, busy0, overrun0, sync_err0;

  int checks = 0;
  int failures = 0;

  // reference model state: bits of the frame in progress, and expected words per bit order
  bit           frame[$];
  bit           m_inframe = 1'b0;
  bit           m_ov = 1'b0;
  bit           m_ovr = 1'b0;
  bit           m_serr = 1'b0;
  logic [W-1:0] exp1[$];
  logic [W-1:0] exp0[$];

  always #5 clk = ~clk;

  shift_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .clr_err(clr_err), .out_ready(out_ready), .out(out), .out_valid(out_valid),
    .busy(busy), .overrun(overrun), .sync_err(sync_err)
  );

  shift_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .clr_err(clr_err), .out_ready(out_ready), .out(out0), .out_valid(out_valid0),
    .busy(busy0), .overrun(overrun0), .sync_err(sync_err0)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour at one rising edge, using the inputs currently applied.
  task automatic model_edge();
    bit           done = 1'b0;
    bit           serr = 1'b0;
    logic [W-1:0] w1 = '0;
    logic [W-1:0] w0 = '0;
    if (sin_valid) begin
      if (sof) begin
        serr = m_inframe;
        frame.delete();
        frame.push_back(sin);
        m_inframe = 1'b1;
      end else if (m_inframe) begin
        frame.push_back(sin);
        if (frame.size() == W) begin
          for (int k = 0; k < W; k++) begin
            w1[W-1-k] = frame[k];
            w0[k]     = frame[k];
          end
          done = 1'b1;
          m_inframe = 1'b0;
          frame.delete();
        end
      end
    end
    if (done && m_ov && !out_ready) begin
      m_ovr = 1'b1;
    end else begin
      if (clr_err) m_ovr = 1'b0;
      if (done) begin
        exp1.push_back(w1);
        exp0.push_back(w0);
        m_ov = 1'b1;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
    end
    m_serr = serr;
  endtask

  task automatic step(input bit v, input bit s, input bit f, input bit r, input bit c);
    sin_valid = v;
    sin = s;
    sof = f;
    out_ready = r;
    clr_err = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out"}, int'(out), 0);
    chk({tag, "_out0"}, int'(out0), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
    chk({tag, "_sync_err"}, int'(sync_err), 0);
  endtask

  // asynchronous reset in the middle of a cycle
  task automatic mid_reset();
    #2 rst = 1'b0;
    #1 check_zero("async_rst");
    frame.delete();
    exp1.delete();
    exp0.delete();
    m_inframe = 1'b0;
    m_ov = 1'b0;
    m_ovr = 1'b0;
    m_serr = 1'b0;
    sin_valid = 1'b0;
    sof = 1'b0;
    #3 rst = 1'b1;
    step(0, 0, 0, 0, 0);
  endtask

  // Monitor: compares control outputs every cycle and pops the scoreboard on each handshake.
  always begin
    @(negedge clk);
    chk("mon_busy", int'(busy), int'(m_inframe));
    chk("mon_overrun", int'(overrun), int'(m_ovr));
    chk("mon_sync_err", int'(sync_err), int'(m_serr));
    chk("mon_out_valid", int'(out_valid), int'(m_ov));
    chk("mon_out_valid0", int'(out_valid0), int'(m_ov));
    if (out_valid && out_ready) begin
      if (exp1.size() == 0 || exp0.size() == 0) begin
        chk("mon_unexpected_word", 1, 0);
      end else begin
        chk("mon_word_msb", int'(out), int'(exp1.pop_front()));
        chk("mon_word_lsb", int'(out0), int'(exp0.pop_front()));
      end
    end
  end

  initial begin
    #1 check_zero("reset");
    #11 rst = 1'b1;
    @(posedge clk);
    #1;

    // back-to-back frame 1011
    step(1, 1, 1, 1, 0); step(1, 0, 0, 1, 0); step(1, 1, 0, 1, 0); step(1, 1, 0, 1, 0);
    chk("b2b_out", int'(out), 4'b1011);
    chk("b2b_valid", int'(out_valid), 1);
    step(0, 0, 0, 1, 0);
    chk("b2b_valid_one_cycle", int'(out_valid), 0);

    // same frame with gaps between bits
    step(1, 1, 1, 1, 0);
    for (int i = 1; i < W; i++) begin
      for (int g = 0; g < i; g++) begin
        step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 0);
        chk("gap_busy", int'(busy), 1);
      end
      step(1, (i == 1) ? 1'b0 : 1'b1, 0, 1, 0);
    end
    chk("gap_out", int'(out), 4'b1011);
    step(0, 0, 0, 1, 0);

    // overrun with consumer stalled
    step(1, 1, 1, 0, 0); step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0); step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
    chk("ovr_out_held", int'(out), 4'b1011);
    chk("ovr_set", int'(overrun), 1);
    step(0, 0, 0, 0, 1);
    chk("ovr_cleared", int'(overrun), 0);
    step(0, 0, 0, 1, 0);
    chk("ovr_drained", int'(out_valid), 0);

    // early sof aborts the partial frame
    step(1, 1, 1, 1, 0); step(1, 1, 0, 1, 0); step(1, 0, 1, 1, 0);
    chk("sync_pulse", int'(sync_err), 1);
    step(1, 1, 0, 1, 0);
    chk("sync_pulse_end", int'(sync_err), 0);
    step(1, 0, 0, 1, 0); step(1, 1, 0, 1, 0);
    chk("sync_out", int'(out), 4'b0101);
    step(0, 0, 0, 1, 0);

    // reset mid-frame, then a clean frame
    step(1, 1, 1, 1, 0); step(1, 0, 0, 1, 0); step(1, 1, 0, 1, 0);
    mid_reset();
    step(1, 1, 0, 1, 0);
    chk("post_rst_no_sof_ignored", int'(busy), 0);
    step(1, 1, 1, 1, 0); step(1, 0, 0, 1, 0); step(1, 0, 0, 1, 0); step(1, 1, 0, 1, 0);
    chk("post_rst_out", int'(out), 4'b1001);
    step(0, 0, 0, 1, 0);

    // bit order comparison between the two instances
    step(1, 1, 1, 1, 0); step(1, 0, 0, 1, 0); step(1, 0, 0, 1, 0); step(1, 0, 0, 1, 0);
    chk("lsb_first_out", int'(out0), 4'b0001);
    chk("msb_first_out", int'(out), 4'b1000);
    step(0, 0, 0, 1, 0);

    // random traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      if (i == 300) mid_reset();
      step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 2,
           $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 1);
    end

    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    chk("drain_empty", exp1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
